// File: rtl/collision_pkg.sv
// collision_pkg: shared axis indices, pipeline latencies, the wide signed
// arithmetic type and a saturation helper for the edge collision resolver.
// Optional build macro used by the resolver: COLLISION_RESTITUTION_EN.
package collision_pkg;

    localparam int X_IDX = 0;
    localparam int Y_IDX = 1;

    // Input strobe to output strobe, in clock cycles.
    localparam int COLLISION_LATENCY = 8;

    // Register stages inside each pipelined divider.
    localparam int DIV_LATENCY = 3;

    // Wide enough for t*d products (about 2*POSITION_SIZE + POSITION_SIZE + 3 bits)
    // and s*n products (about POSITION_SIZE + VELOCITY_SIZE + POSITION_SIZE + 4 bits).
    localparam int WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    // Per-item data that rides alongside the dividers unchanged.
    typedef struct packed {
        logic  hit;
        wide_t px;
        wide_t py;
        wide_t vx;
        wide_t vy;
        wide_t fx;
        wide_t fy;
    } side_t;

    // Clamp a wide signed value into the signed range of a narrower field.
    function automatic wide_t saturate(input wide_t value, input int bits);
        wide_t max_val;
        wide_t min_val;
        max_val = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
        min_val = -max_val - wide_t'(1);
        if (value > max_val) begin
            return max_val;
        end
        if (value < min_val) begin
            return min_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/collision_div_pipe.sv
// collision_div_pipe: signed divider truncating toward zero, with a fixed
// latency of STAGES cycles. A zero divisor yields a zero quotient, which covers
// degenerate edges and parallel motion (those results are never selected).
module collision_div_pipe
    import collision_pkg::*;
#(
    parameter int STAGES = DIV_LATENCY
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  wide_t numerator,
    input  wide_t denominator,
    output wide_t quotient
);

    localparam wide_t ZERO = '0;

    wide_t raw_q;
    wide_t stage_q [STAGES];

    // Combinational quotient; SystemVerilog signed division truncates toward zero.
    always_comb begin
        raw_q = ZERO;
        if (denominator != ZERO) begin
            raw_q = numerator / denominator;
        end
    end

    // Register the quotient, then delay it to the fixed pipeline latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= ZERO;
            end
        end else begin
            stage_q[0] <= raw_q;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign quotient = stage_q[STAGES-1];

endmodule

// File: rtl/collision_new_values.sv
// collision_new_values: per-edge swept-segment collision resolver.
// Eight-stage pipeline accepting one item per cycle:
//   1 capture / edge and offset vectors, 2 cross products, 3 sign fix and hit
//   test, 4-6 dividers, 7 resolve motion, 8 saturate into output registers.
// Build macro COLLISION_RESTITUTION_EN reflects the normal velocity component
// instead of removing it.
module collision_new_values
    import collision_pkg::*;
#(
    parameter int POSITION_SIZE     = 15,
    parameter int VELOCITY_SIZE     = 10,
    parameter int ACCELERATION_SIZE = 8,
    parameter int DT                = 1
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 input_valid,
    input  logic [1:0][POSITION_SIZE-1:0]        v1_in,
    input  logic [1:0][POSITION_SIZE-1:0]        v2_in,
    input  logic signed [POSITION_SIZE-1:0]      pos_x,
    input  logic signed [POSITION_SIZE-1:0]      pos_y,
    input  logic signed [VELOCITY_SIZE-1:0]      vel_x,
    input  logic signed [VELOCITY_SIZE-1:0]      vel_y,
    input  logic signed [POSITION_SIZE-1:0]      dx,
    input  logic signed [POSITION_SIZE-1:0]      dy,
    output logic signed [POSITION_SIZE-1:0]      x_new_out,
    output logic signed [POSITION_SIZE-1:0]      y_new_out,
    output logic signed [VELOCITY_SIZE-1:0]      vx_new_out,
    output logic signed [VELOCITY_SIZE-1:0]      vy_new_out,
    output logic signed [POSITION_SIZE-1:0]      x_int_out,
    output logic signed [POSITION_SIZE-1:0]      y_int_out,
    output logic signed [ACCELERATION_SIZE-1:0]  acceleration_x_out,
    output logic signed [ACCELERATION_SIZE-1:0]  acceleration_y_out,
    output logic                                 collision,
    output logic                                 output_valid
);

    localparam wide_t ZERO = '0;
    localparam wide_t DT_W = wide_t'(DT);

`ifdef COLLISION_RESTITUTION_EN
    localparam wide_t NORMAL_GAIN = wide_t'(2);
`else
    localparam wide_t NORMAL_GAIN = wide_t'(1);
`endif

    // Stage 1 registers
    logic  s1_valid;
    wide_t s1_ex, s1_ey, s1_wx, s1_wy;
    wide_t s1_px, s1_py, s1_vx, s1_vy, s1_dx, s1_dy;

    // Stage 2 registers
    logic  s2_valid;
    wide_t s2_den, s2_tn, s2_un, s2_nsq, s2_s;
    wide_t s2_ex, s2_ey;
    wide_t s2_px, s2_py, s2_vx, s2_vy, s2_dx, s2_dy;

    // Stage 3 combinational and registers
    wide_t den_n, tn_n, un_n;
    logic  hit;
    logic  s3_valid;
    wide_t s3_tdx, s3_tdy, s3_den, s3_snx, s3_sny, s3_nsq;
    side_t s3_side;

    // Divider outputs and matching side pipeline
    wide_t q_tx, q_ty, q_vnx, q_vny;
    side_t side_pipe [DIV_LATENCY];
    logic [DIV_LATENCY-1:0] valid_pipe;

    // Stage 7 combinational and registers
    side_t side;
    wide_t push_x, push_y;
    wide_t res_x, res_y, res_vx, res_vy, res_ax, res_ay;
    logic  s7_valid, s7_hit;
    wide_t s7_x, s7_y, s7_vx, s7_vy, s7_ax, s7_ay;

    // Capture the item and form e = B - A and w = A - P at full width.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_ex <= ZERO;
            s1_ey <= ZERO;
            s1_wx <= ZERO;
            s1_wy <= ZERO;
            s1_px <= ZERO;
            s1_py <= ZERO;
            s1_vx <= ZERO;
            s1_vy <= ZERO;
            s1_dx <= ZERO;
            s1_dy <= ZERO;
        end else begin
            s1_valid <= input_valid;
            s1_ex <= wide_t'($signed(v2_in[X_IDX])) - wide_t'($signed(v1_in[X_IDX]));
            s1_ey <= wide_t'($signed(v2_in[Y_IDX])) - wide_t'($signed(v1_in[Y_IDX]));
            s1_wx <= wide_t'($signed(v1_in[X_IDX])) - wide_t'(pos_x);
            s1_wy <= wide_t'($signed(v1_in[Y_IDX])) - wide_t'(pos_y);
            s1_px <= wide_t'(pos_x);
            s1_py <= wide_t'(pos_y);
            s1_vx <= wide_t'(vel_x);
            s1_vy <= wide_t'(vel_y);
            s1_dx <= wide_t'(dx);
            s1_dy <= wide_t'(dy);
        end
    end

    // Cross products for the intersection parameters, edge length squared and v.n.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_den <= ZERO;
            s2_tn  <= ZERO;
            s2_un  <= ZERO;
            s2_nsq <= ZERO;
            s2_s   <= ZERO;
            s2_ex  <= ZERO;
            s2_ey  <= ZERO;
            s2_px  <= ZERO;
            s2_py  <= ZERO;
            s2_vx  <= ZERO;
            s2_vy  <= ZERO;
            s2_dx  <= ZERO;
            s2_dy  <= ZERO;
        end else begin
            s2_valid <= s1_valid;
            s2_den <= s1_dx * s1_ey - s1_dy * s1_ex;
            s2_tn  <= s1_wx * s1_ey - s1_wy * s1_ex;
            s2_un  <= s1_wx * s1_dy - s1_wy * s1_dx;
            s2_nsq <= s1_ex * s1_ex + s1_ey * s1_ey;
            s2_s   <= s1_vx * s1_ey - s1_vy * s1_ex;
            s2_ex  <= s1_ex;
            s2_ey  <= s1_ey;
            s2_px  <= s1_px;
            s2_py  <= s1_py;
            s2_vx  <= s1_vx;
            s2_vy  <= s1_vy;
            s2_dx  <= s1_dx;
            s2_dy  <= s1_dy;
        end
    end

    // Force a positive denominator, then test both parameters against [0, den].
    always_comb begin
        den_n = s2_den;
        tn_n  = s2_tn;
        un_n  = s2_un;
        if (s2_den < ZERO) begin
            den_n = -s2_den;
            tn_n  = -s2_tn;
            un_n  = -s2_un;
        end
        hit = (den_n != ZERO) && (tn_n >= ZERO) && (tn_n <= den_n)
              && (un_n >= ZERO) && (un_n <= den_n);
    end

    // Register the hit flag, the divider operands and the pass-through position.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s3_valid <= 1'b0;
            s3_tdx   <= ZERO;
            s3_tdy   <= ZERO;
            s3_den   <= ZERO;
            s3_snx   <= ZERO;
            s3_sny   <= ZERO;
            s3_nsq   <= ZERO;
            s3_side  <= '0;
        end else begin
            s3_valid   <= s2_valid;
            s3_tdx     <= tn_n * s2_dx;
            s3_tdy     <= tn_n * s2_dy;
            s3_den     <= den_n;
            s3_snx     <= s2_s * s2_ey;
            s3_sny     <= -(s2_s * s2_ex);
            s3_nsq     <= s2_nsq;
            s3_side.hit <= hit;
            s3_side.px <= s2_px;
            s3_side.py <= s2_py;
            s3_side.vx <= s2_vx;
            s3_side.vy <= s2_vy;
            s3_side.fx <= s2_px + s2_dx;
            s3_side.fy <= s2_py + s2_dy;
        end
    end

    collision_div_pipe #(.STAGES(DIV_LATENCY)) div_tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .numerator   (s3_tdx),
        .denominator (s3_den),
        .quotient    (q_tx)
    );

    collision_div_pipe #(.STAGES(DIV_LATENCY)) div_ty (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .numerator   (s3_tdy),
        .denominator (s3_den),
        .quotient    (q_ty)
    );

    collision_div_pipe #(.STAGES(DIV_LATENCY)) div_vnx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .numerator   (s3_snx),
        .denominator (s3_nsq),
        .quotient    (q_vnx)
    );

    collision_div_pipe #(.STAGES(DIV_LATENCY)) div_vny (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .numerator   (s3_sny),
        .denominator (s3_nsq),
        .quotient    (q_vny)
    );

    // Delay the per-item side data and valid bit to line up with the quotients.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_pipe <= '0;
            for (int i = 0; i < DIV_LATENCY; i++) begin
                side_pipe[i] <= '0;
            end
        end else begin
            valid_pipe[0] <= s3_valid;
            side_pipe[0]  <= s3_side;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                side_pipe[i]  <= side_pipe[i-1];
            end
        end
    end

    // Choose clamped or free motion and derive the normal-velocity correction.
    always_comb begin
        side   = side_pipe[DIV_LATENCY-1];
        push_x = q_vnx * NORMAL_GAIN;
        push_y = q_vny * NORMAL_GAIN;
        res_x  = side.fx;
        res_y  = side.fy;
        res_vx = side.vx;
        res_vy = side.vy;
        res_ax = ZERO;
        res_ay = ZERO;
        if (side.hit) begin
            res_x  = side.px + q_tx;
            res_y  = side.py + q_ty;
            res_vx = side.vx - push_x;
            res_vy = side.vy - push_y;
            res_ax = (-push_x) / DT_W;
            res_ay = (-push_y) / DT_W;
        end
    end

    // Register the resolved full-width results.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s7_valid <= 1'b0;
            s7_hit   <= 1'b0;
            s7_x     <= ZERO;
            s7_y     <= ZERO;
            s7_vx    <= ZERO;
            s7_vy    <= ZERO;
            s7_ax    <= ZERO;
            s7_ay    <= ZERO;
        end else begin
            s7_valid <= valid_pipe[DIV_LATENCY-1];
            s7_hit   <= side.hit;
            s7_x     <= res_x;
            s7_y     <= res_y;
            s7_vx    <= res_vx;
            s7_vy    <= res_vy;
            s7_ax    <= res_ax;
            s7_ay    <= res_ay;
        end
    end

    // Saturate into the output registers, which hold their value between strobes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            output_valid       <= 1'b0;
            collision          <= 1'b0;
            x_new_out          <= '0;
            y_new_out          <= '0;
            x_int_out          <= '0;
            y_int_out          <= '0;
            vx_new_out         <= '0;
            vy_new_out         <= '0;
            acceleration_x_out <= '0;
            acceleration_y_out <= '0;
        end else begin
            output_valid <= s7_valid;
            if (s7_valid) begin
                collision          <= s7_hit;
                x_new_out          <= POSITION_SIZE'(saturate(s7_x, POSITION_SIZE));
                y_new_out          <= POSITION_SIZE'(saturate(s7_y, POSITION_SIZE));
                x_int_out          <= POSITION_SIZE'(saturate(s7_x, POSITION_SIZE));
                y_int_out          <= POSITION_SIZE'(saturate(s7_y, POSITION_SIZE));
                vx_new_out         <= VELOCITY_SIZE'(saturate(s7_vx, VELOCITY_SIZE));
                vy_new_out         <= VELOCITY_SIZE'(saturate(s7_vy, VELOCITY_SIZE));
                acceleration_x_out <= ACCELERATION_SIZE'(saturate(s7_ax, ACCELERATION_SIZE));
                acceleration_y_out <= ACCELERATION_SIZE'(saturate(s7_ay, ACCELERATION_SIZE));
            end
        end
    end

endmodule

// File: tb/tb_collision_new_values.sv
// tb_collision_new_values: directed self-checking bench for collision_new_values.
// Honors COLLISION_RESTITUTION_EN for the expected velocity and acceleration.
module tb_collision_new_values;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              input_valid;
    logic [1:0][14:0]  v1_in;
    logic [1:0][14:0]  v2_in;
    logic signed [14:0] pos_x, pos_y, dx, dy;
    logic signed [9:0]  vel_x, vel_y;
    logic signed [14:0] x_new_out, y_new_out, x_int_out, y_int_out;
    logic signed [9:0]  vx_new_out, vy_new_out;
    logic signed [7:0]  acceleration_x_out, acceleration_y_out;
    logic               collision, output_valid;

    int checks = 0;
    int failures = 0;

`ifdef COLLISION_RESTITUTION_EN
    localparam int GAIN = 2;
`else
    localparam int GAIN = 1;
`endif

    always #5 clk_in = ~clk_in;

    collision_new_values dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .input_valid        (input_valid),
        .v1_in              (v1_in),
        .v2_in              (v2_in),
        .pos_x              (pos_x),
        .pos_y              (pos_y),
        .vel_x              (vel_x),
        .vel_y              (vel_y),
        .dx                 (dx),
        .dy                 (dy),
        .x_new_out          (x_new_out),
        .y_new_out          (y_new_out),
        .vx_new_out         (vx_new_out),
        .vy_new_out         (vy_new_out),
        .x_int_out          (x_int_out),
        .y_int_out          (y_int_out),
        .acceleration_x_out (acceleration_x_out),
        .acceleration_y_out (acceleration_y_out),
        .collision          (collision),
        .output_valid       (output_valid)
    );

    // Drive one item's data; the edge is always A=(-100,-100), B=(100,-100).
    task automatic apply_stimulus(input int px, input int py, input int vx,
                                  input int vy, input int ddx, input int ddy);
        v1_in[0] = 15'(-100);
        v1_in[1] = 15'(-100);
        v2_in[0] = 15'(100);
        v2_in[1] = 15'(-100);
        pos_x = 15'(px);
        pos_y = 15'(py);
        vel_x = 10'(vx);
        vel_y = 10'(vy);
        dx = 15'(ddx);
        dy = 15'(ddy);
    endtask

    // Strobe one item for a single cycle; returns #1 after the capturing edge.
    task automatic pulse_item(input int px, input int py, input int vx,
                              input int vy, input int ddx, input int ddy);
        apply_stimulus(px, py, vx, vy, ddx, ddy);
        input_valid = 1'b1;
        @(posedge clk_in);
        #1;
        input_valid = 1'b0;
    endtask

    // Wait (bounded) for output_valid; edges counts clock edges including the capture edge.
    task automatic wait_strobe(inout int edges);
        while (output_valid !== 1'b1 && edges < 30) begin
            @(posedge clk_in);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        input_valid = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset.output_valid got=%0b exp=0", output_valid); end
        checks++; if (x_new_out !== 0 || y_int_out !== 0) begin failures++; $display("[TB] FAIL reset.position got=%0d,%0d exp=0,0", x_new_out, y_int_out); end
        checks++; if (collision !== 1'b0 || vx_new_out !== 0 || acceleration_y_out !== 0) begin failures++; $display("[TB] FAIL reset.misc got=%0b,%0d,%0d exp=0,0,0", collision, vx_new_out, acceleration_y_out); end
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        checks++; if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset.idle_valid got=%0b exp=0", output_valid); end
    endtask

    task automatic test_no_hit();
        int edges = 1;
        pulse_item(40, -70, 5, 5, 3, 7);
        wait_strobe(edges);
        checks++; if (edges !== 8) begin failures++; $display("[TB] FAIL no_hit.latency got=%0d exp=8", edges); end
        checks++; if (collision !== 1'b0) begin failures++; $display("[TB] FAIL no_hit.collision got=%0b exp=0", collision); end
        checks++; if (x_new_out !== 43 || y_new_out !== -63) begin failures++; $display("[TB] FAIL no_hit.new got=%0d,%0d exp=43,-63", x_new_out, y_new_out); end
        checks++; if (x_int_out !== 43 || y_int_out !== -63) begin failures++; $display("[TB] FAIL no_hit.int got=%0d,%0d exp=43,-63", x_int_out, y_int_out); end
        checks++; if (vx_new_out !== 5 || vy_new_out !== 5) begin failures++; $display("[TB] FAIL no_hit.vel got=%0d,%0d exp=5,5", vx_new_out, vy_new_out); end
        checks++; if (acceleration_x_out !== 0 || acceleration_y_out !== 0) begin failures++; $display("[TB] FAIL no_hit.accel got=%0d,%0d exp=0,0", acceleration_x_out, acceleration_y_out); end
        @(posedge clk_in);
        #1;
        checks++; if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL no_hit.strobe_width got=%0b exp=0", output_valid); end
    endtask

    task automatic test_hit();
        int edges = 1;
        pulse_item(40, -85, 5, -5, 10, -20);
        wait_strobe(edges);
        checks++; if (edges !== 8) begin failures++; $display("[TB] FAIL hit.latency got=%0d exp=8", edges); end
        checks++; if (collision !== 1'b1) begin failures++; $display("[TB] FAIL hit.collision got=%0b exp=1", collision); end
        checks++; if (x_int_out !== 47 || y_int_out !== -100) begin failures++; $display("[TB] FAIL hit.int got=%0d,%0d exp=47,-100", x_int_out, y_int_out); end
        checks++; if (x_new_out !== 47 || y_new_out !== -100) begin failures++; $display("[TB] FAIL hit.new got=%0d,%0d exp=47,-100", x_new_out, y_new_out); end
        checks++; if (vx_new_out !== 5 || vy_new_out !== -5 + 5 * GAIN) begin failures++; $display("[TB] FAIL hit.vel got=%0d,%0d exp=5,%0d", vx_new_out, vy_new_out, -5 + 5 * GAIN); end
        checks++; if (acceleration_x_out !== 0 || acceleration_y_out !== 5 * GAIN) begin failures++; $display("[TB] FAIL hit.accel got=%0d,%0d exp=0,%0d", acceleration_x_out, acceleration_y_out, 5 * GAIN); end
    endtask

    task automatic test_parallel();
        int edges = 1;
        pulse_item(0, -90, 1, 2, 20, 0);
        wait_strobe(edges);
        checks++; if (edges !== 8) begin failures++; $display("[TB] FAIL parallel.latency got=%0d exp=8", edges); end
        checks++; if (collision !== 1'b0) begin failures++; $display("[TB] FAIL parallel.collision got=%0b exp=0", collision); end
        checks++; if (x_new_out !== 20 || y_new_out !== -90) begin failures++; $display("[TB] FAIL parallel.new got=%0d,%0d exp=20,-90", x_new_out, y_new_out); end
        checks++; if (vx_new_out !== 1 || vy_new_out !== 2) begin failures++; $display("[TB] FAIL parallel.vel got=%0d,%0d exp=1,2", vx_new_out, vy_new_out); end
    endtask

    task automatic test_endpoint();
        int edges = 1;
        pulse_item(100, -90, 3, 4, 0, -10);
        wait_strobe(edges);
        checks++; if (edges !== 8) begin failures++; $display("[TB] FAIL endpoint.latency got=%0d exp=8", edges); end
        checks++; if (collision !== 1'b1) begin failures++; $display("[TB] FAIL endpoint.collision got=%0b exp=1", collision); end
        checks++; if (x_int_out !== 100 || y_int_out !== -100) begin failures++; $display("[TB] FAIL endpoint.int got=%0d,%0d exp=100,-100", x_int_out, y_int_out); end
        checks++; if (vx_new_out !== 3 || vy_new_out !== 4 - 4 * GAIN) begin failures++; $display("[TB] FAIL endpoint.vel got=%0d,%0d exp=3,%0d", vx_new_out, vy_new_out, 4 - 4 * GAIN); end
        checks++; if (acceleration_y_out !== -4 * GAIN) begin failures++; $display("[TB] FAIL endpoint.accel_y got=%0d exp=%0d", acceleration_y_out, -4 * GAIN); end
    endtask

    task automatic test_saturation();
        int edges = 1;
        pulse_item(40, -85, -512, 511, 10, -20);
        wait_strobe(edges);
        checks++; if (collision !== 1'b1) begin failures++; $display("[TB] FAIL sat_vel.collision got=%0b exp=1", collision); end
        checks++; if (vx_new_out !== -512 || vy_new_out !== 511 - 511 * GAIN) begin failures++; $display("[TB] FAIL sat_vel.vel got=%0d,%0d exp=-512,%0d", vx_new_out, vy_new_out, 511 - 511 * GAIN); end
        checks++; if (acceleration_x_out !== 0 || acceleration_y_out !== -128) begin failures++; $display("[TB] FAIL sat_vel.accel got=%0d,%0d exp=0,-128", acceleration_x_out, acceleration_y_out); end
        edges = 1;
        pulse_item(16380, 0, 1, 1, 100, 0);
        wait_strobe(edges);
        checks++; if (collision !== 1'b0) begin failures++; $display("[TB] FAIL sat_pos.collision got=%0b exp=0", collision); end
        checks++; if (x_new_out !== 16383 || x_int_out !== 16383 || y_new_out !== 0) begin failures++; $display("[TB] FAIL sat_pos.new got=%0d,%0d,%0d exp=16383,16383,0", x_new_out, x_int_out, y_new_out); end
    endtask

    task automatic test_back_to_back();
        int edges = 2;
        apply_stimulus(40, -85, 5, -5, 10, -20);
        input_valid = 1'b1;
        @(posedge clk_in);
        #1;
        apply_stimulus(40, -70, 5, 5, 3, 7);
        @(posedge clk_in);
        #1;
        input_valid = 1'b0;
        wait_strobe(edges);
        checks++; if (edges !== 8) begin failures++; $display("[TB] FAIL b2b.first_latency got=%0d exp=8", edges); end
        checks++; if (collision !== 1'b1 || y_new_out !== -100 || x_new_out !== 47) begin failures++; $display("[TB] FAIL b2b.first_data got=%0b,%0d,%0d exp=1,47,-100", collision, x_new_out, y_new_out); end
        @(posedge clk_in);
        #1;
        checks++; if (output_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b.second_valid got=%0b exp=1", output_valid); end
        checks++; if (collision !== 1'b0 || x_new_out !== 43 || y_new_out !== -63 || vy_new_out !== 5) begin failures++; $display("[TB] FAIL b2b.second_data got=%0b,%0d,%0d,%0d exp=0,43,-63,5", collision, x_new_out, y_new_out, vy_new_out); end
        @(posedge clk_in);
        #1;
        checks++; if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b.after_valid got=%0b exp=0", output_valid); end
        checks++; if (x_new_out !== 43 || y_int_out !== -63) begin failures++; $display("[TB] FAIL b2b.hold got=%0d,%0d exp=43,-63", x_new_out, y_int_out); end
    endtask

    task automatic test_reset_in_flight();
        logic seen = 1'b0;
        pulse_item(40, -85, 5, -5, 10, -20);
        repeat (3) @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (x_new_out !== 0 || y_int_out !== 0) begin failures++; $display("[TB] FAIL flight_reset.position got=%0d,%0d exp=0,0", x_new_out, y_int_out); end
        checks++; if (vx_new_out !== 0 || vy_new_out !== 0 || output_valid !== 1'b0) begin failures++; $display("[TB] FAIL flight_reset.vel got=%0d,%0d,%0b exp=0,0,0", vx_new_out, vy_new_out, output_valid); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_in);
            #1;
            if (output_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL flight_reset.dropped got=%0b exp=0", seen); end
    endtask

    initial begin
        $display("[TB] collision_new_values directed bench, restitution gain %0d", GAIN);
        test_reset();
        test_no_hit();
        test_hit();
        test_parallel();
        test_endpoint();
        test_saturation();
        test_back_to_back();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_new_values.md
Name: collision_new_values

Overview:
Per-edge collision resolver for the soft-body car physics. Takes one body point (position, velocity, proposed displacement) and one obstacle edge v1→v2, and tests whether the swept segment P→P+d crosses the edge. On a hit it outputs the clamped position, the velocity with its edge-normal component removed, and the corrective acceleration; otherwise it passes the motion through. It sits between the per-point update engine and the obstacle-edge iterator.

Parameters:
POSITION_SIZE, 15, signed width of positions, displacements and edge vertices
VELOCITY_SIZE, 10, signed width of velocities
ACCELERATION_SIZE, 8, signed width of acceleration outputs
DT, 1, timestep divisor for acceleration (positive integer)

Ports:
clk_in  in  1  clock; all logic on its rising edge
rst_in  in  1  reset, asynchronous, active-high
input_valid  in  1  one-cycle strobe; captures all data inputs
v1_in  in  [1:0] x signed POSITION_SIZE  edge start A; [0]=x, [1]=y
v2_in  in  [1:0] x signed POSITION_SIZE  edge end B
pos_x, pos_y  in  signed POSITION_SIZE  point position P
vel_x, vel_y  in  signed VELOCITY_SIZE  point velocity v
dx, dy  in  signed POSITION_SIZE  proposed displacement d for this step
x_new_out, y_new_out  out  signed POSITION_SIZE  resolved position
vx_new_out, vy_new_out  out  signed VELOCITY_SIZE  resolved velocity
x_int_out, y_int_out  out  signed POSITION_SIZE  intersection point
acceleration_x_out, acceleration_y_out  out  signed ACCELERATION_SIZE  corrective acceleration
collision  out  1  swept segment hit the edge
output_valid  out  1  one-cycle strobe; outputs valid

Behaviour:
- Reset (async, active-high): all outputs 0, all pipeline valid bits cleared. Reset mid-operation drops in-flight items; no output_valid is produced for them.
- Fully pipelined, fixed latency of 8 cycles from input_valid to output_valid. Accepts a new item every cycle; no back-pressure. Outputs are registered and hold their value between strobes.
- Intermediates: e=B−A, w=A−P.
  - den = dx·ey − dy·ex
  - tn = wx·ey − wy·ex
  - un = wx·dy − wy·dx
- Internal width must hold full products and sums without overflow: ≥ 2·POSITION_SIZE+VELOCITY_SIZE+4 bits.
- Hit test:
  - If den<0, negate den, tn and un.
  - collision = (den≠0) and 0≤tn≤den and 0≤un≤den (endpoints inclusive). Parallel or degenerate edges give no hit.
- On collision:
  - x_int = pos_x + trunc(tn·dx/den); y_int = pos_y + trunc(tn·dy/den). Division truncates toward zero.
  - x_new/y_new = x_int/y_int.
  - Normal n = (ey, −ex); s = v·n; vn = trunc(s·n/|n|²) per component.
  - v_new = v − vn.
  - accel = trunc(−vn/DT).
- No collision: x_new = pos_x+dx, y_new = pos_y+dy; x_int/y_int = x_new/y_new; v_new = v; accel = 0.
- All outputs saturate to their signed range; they never wrap.

Optional Feature:
COLLISION_RESTITUTION_EN: when defined, hits reflect the velocity: v_new = v − 2·vn and accel = trunc(−2·vn/DT). When undefined, the normal component is zeroed as in Behaviour. Latency is identical either way.

Decomposition:
- Package collision_pkg holds:
  - X_IDX=0, Y_IDX=1
  - COLLISION_LATENCY=8
  - internal wide signed typedef and a saturation function
- One sub-module, collision_div_pipe: pipelined signed truncating divider, fixed latency. Used for the t-scaling and normal-projection divisions.

Test Plan:
- No hit: A=(−100,−100), B=(100,−100), P=(40,−70), v=(5,5), d=(3,7) → after 8 cycles: collision=0, new=(43,−63), int=(43,−63), v=(5,5), accel=(0,0).
- Hit: same edge, P=(40,−85), v=(5,−5), d=(10,−20) → collision=1, int=(47,−100), new=(47,−100), v=(5,0), accel=(0,5). With COLLISION_RESTITUTION_EN: v=(5,5), accel=(0,10).
- Parallel: edge as above, P=(0,−90), d=(20,0) → collision=0, new=(20,−90).
- Endpoint touch: P=(100,−90), d=(0,−10), same edge → collision=1, int=(100,−100).
- Back-to-back input_valid on consecutive cycles (the two items above) → two output_valid strobes on consecutive cycles, in order, with correct data.
- Assert rst_in during flight → outputs 0 immediately, no output_valid afterward. Also: saturation case, v=(−512,511) on hit → results clamp, no wrap.
